// File: rtl/gate_accum_array.sv
// gate_accum_array: per-beat selectable bitwise op (NOT / OR-accumulate /
// AND-mask / pass) across CH channels of W bits each. The OR path feeds a
// registered sticky accumulator. Results are queued in a DEPTH-entry FIFO
// with valid/ready handshakes on both sides.
// Optional feature: define GATE_ACCUM_PARITY_EN to drive out_par with the
// per-channel parity of the FIFO head. When it is undefined, out_par is tied to 0.
module gate_accum_array #(
  parameter int CH    = 4,
  parameter int W     = 3,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   in_op,
  input  logic [CH*W-1:0]              in_data,
  input  logic [W-1:0]                 mask,
  input  logic                         clr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CH*W-1:0]              out_data,
  output logic [CH-1:0]                out_par,
  output logic                         acc_any,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    OP_NOT  = 2'b00,
    OP_OR   = 2'b01,
    OP_AND  = 2'b10,
    OP_PASS = 2'b11
  } op_t;

  op_t             op;
  logic [CH*W-1:0] acc;
  logic [CH*W-1:0] acc_eff;
  logic [CH*W-1:0] result;
  logic [CH*W-1:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            push;
  logic            pop;

  assign op        = op_t'(in_op);
  assign in_ready  = (level != LW'(DEPTH));
  assign out_valid = (level != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign acc_any   = |acc;

  // Pointers advance modulo DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) next_ptr = '0;
    else                     next_ptr = p + 1'b1;
  endfunction

  // Per-channel result; a same-cycle clr makes the OR path see an empty accumulator.
  always_comb begin
    acc_eff = clr ? '0 : acc;
    result  = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      case (op)
        OP_NOT:  result[c*W +: W] = ~in_data[c*W +: W];
        OP_OR:   result[c*W +: W] = acc_eff[c*W +: W] | in_data[c*W +: W];
        OP_AND:  result[c*W +: W] = in_data[c*W +: W] & mask;
        default: result[c*W +: W] = in_data[c*W +: W];
      endcase
    end
  end

  // Sticky accumulator: clr wins over any accepted OR beat in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      acc <= '0;
    else if (clr)                 acc <= '0;
    else if (push && op == OP_OR) acc <= acc | in_data;
  end

  // FIFO storage; contents are only observable through level-gated reads.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= result;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Head of FIFO, forced to zero when empty.
  always_comb begin
    out_data = out_valid ? mem[rd_ptr] : '0;
  end

`ifdef GATE_ACCUM_PARITY_EN
  // Per-channel parity of the FIFO head.
  always_comb begin
    out_par = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      out_par[c] = ^out_data[c*W +: W];
    end
  end
`else
  assign out_par = '0;
`endif

endmodule

// File: tb/tb_gate_accum_array.sv
// Scoreboard bench for gate_accum_array (CH=4, W=3, DEPTH=2). The driver
// pushes hand-computed results when a beat is accepted. The monitor pops and
// compares on every observed pop.
module tb_gate_accum_array;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [11:0] in_data;
  logic [2:0]  mask;
  logic        clr;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic [3:0]  out_par;
  logic        acc_any;
  logic [1:0]  level;

  int tests = 0;
  int fails = 0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  gate_accum_array #(.CH(4), .W(3), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_data(in_data), .mask(mask), .clr(clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_par(out_par), .acc_any(acc_any), .level(level)
  );

  function automatic logic [3:0] par_of(input logic [11:0] d);
    logic [3:0] p;
    p = 4'b0000;
`ifdef GATE_ACCUM_PARITY_EN
    for (int c = 0; c < 4; c++) p[c] = ^d[c*3 +: 3];
`endif
    return p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: a pop happens on the next rising edge when valid && ready at negedge.
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", {20'd0, out_data}, 32'hFFFF_FFFF);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        chk("out_data", {20'd0, out_data}, {20'd0, e});
        chk("out_par",  {28'd0, out_par},  {28'd0, par_of(e)});
      end
    end
  end

  // Offer one beat; on acceptance push its expected result. Returns at posedge+1.
  task automatic send(input logic [1:0] op, input logic [11:0] d, input logic [2:0] m,
                      input logic c, input logic [11:0] e);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    mask     = m;
    clr      = c;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && (level != 2'd0 || exp_q.size() != 0); n++) @(posedge clk);
    #1;
    chk("drain_level", {30'd0, level}, 32'd0);
    chk("drain_queue", exp_q.size(), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_data = '0; mask = '0;
    clr = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_level",     {30'd0, level},     32'd0);
    chk("rst_out_data",  {20'd0, out_data},  32'd0);
    chk("rst_acc_any",   {31'd0, acc_any},   32'd0);
    chk("rst_out_par",   {28'd0, out_par},   32'd0);
    #20 rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    // NOT, also checking one-cycle latency and parity of head 5A3.
    out_ready = 1'b0;
    send(2'b00, 12'hA5C, 3'b000, 1'b0, 12'h5A3);
    chk("not_latency_valid", {31'd0, out_valid}, 32'd1);
    chk("not_latency_data",  {20'd0, out_data},  32'h5A3);
`ifdef GATE_ACCUM_PARITY_EN
    chk("par_5A3", {28'd0, out_par}, 32'hA);
`else
    chk("par_off", {28'd0, out_par}, 32'h0);
`endif
    out_ready = 1'b1;
    drain();

    // AND-mask and pass.
    send(2'b10, 12'hFFF, 3'b101, 1'b0, 12'hB6D);
    send(2'b11, 12'h3C7, 3'b000, 1'b0, 12'h3C7);
    drain();

    // OR-accumulate, then clr together with an OR beat.
    send(2'b01, 12'h001, 3'b000, 1'b0, 12'h001);
    send(2'b01, 12'h010, 3'b000, 1'b0, 12'h011);
    chk("acc_any_set", {31'd0, acc_any}, 32'd1);
    send(2'b01, 12'h100, 3'b000, 1'b1, 12'h100);
    chk("acc_any_clr_beat", {31'd0, acc_any}, 32'd0);
    drain();

    // clr without a beat leaves the FIFO alone but empties the accumulator.
    send(2'b01, 12'h007, 3'b000, 1'b0, 12'h007);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("acc_any_clr_only", {31'd0, acc_any}, 32'd0);
    send(2'b01, 12'h000, 3'b000, 1'b0, 12'h000);
    drain();

    // Full FIFO: third beat is held until space frees, no bypass.
    out_ready = 1'b0;
    send(2'b11, 12'h111, 3'b000, 1'b0, 12'h111);
    send(2'b11, 12'h222, 3'b000, 1'b0, 12'h222);
    in_valid = 1'b1; in_op = 2'b11; in_data = 12'h333;
    @(negedge clk);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_level",    {30'd0, level},    32'd2);
    chk("hold_head_a",   {20'd0, out_data}, 32'h111);
    @(negedge clk);
    chk("hold_head_b",   {20'd0, out_data}, 32'h111);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(2'b11, 12'h333, 3'b000, 1'b0, 12'h333);
    drain();

    // Asynchronous reset mid-operation.
    out_ready = 1'b0;
    send(2'b01, 12'h001, 3'b000, 1'b0, 12'h001);
    send(2'b00, 12'h002, 3'b000, 1'b0, 12'hFFD);
    chk("pre_rst_level",   {30'd0, level},   32'd2);
    chk("pre_rst_acc_any", {31'd0, acc_any}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_level",     {30'd0, level},     32'd0);
    chk("arst_acc_any",   {31'd0, acc_any},   32'd0);
    chk("arst_out_data",  {20'd0, out_data},  32'd0);
    chk("arst_out_par",   {28'd0, out_par},   32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    send(2'b01, 12'h040, 3'b000, 1'b0, 12'h040);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
